// File: rtl/lfsr_pkg.sv
// Shared definitions for the 10-bit XNOR LFSR: width, taps, lockup value and checker states.
// Used by the stream checker and by any generator that must produce the same sequence.
package lfsr_pkg;

    localparam int unsigned LFSR_W = 10;
    localparam int unsigned TAP_A  = 3;
    localparam int unsigned TAP_B  = 0;

    localparam logic [LFSR_W-1:0] LOCKUP = 10'h3FF;

    typedef enum logic [1:0] {
        StFill,
        StVerify,
        StLocked
    } state_e;

    // New bit entering the top of a right-shifting XNOR LFSR.
    function automatic logic lfsr_next_bit(input logic [LFSR_W-1:0] s);
        return ~(s[TAP_A] ^ s[TAP_B]);
    endfunction

endpackage

// File: rtl/lfsr_predict.sv
// Combinational next-bit predictor for the XNOR LFSR; shared with the generator so both ends
// implement the identical tap rule.
module lfsr_predict
    import lfsr_pkg::*;
(
    input  logic [LFSR_W-1:0] w_i,
    output logic              p_o
);

    assign p_o = lfsr_next_bit(w_i);

endmodule

// File: rtl/lfsr_checker.sv
// Self-synchronising checker for the 10-bit XNOR LFSR serial stream: fill, verify, then flywheel.
// Optional macro LFSR_CHK_ERRCNT_EN builds the 16-bit saturating mismatch counter.
module lfsr_checker
    import lfsr_pkg::*;
#(
    parameter int unsigned SYNC_CHECKS = 8,
    parameter int unsigned LOSS_LIMIT  = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        bit_valid_i,
    input  logic        bit_in_i,
    output logic        locked_o,
    output logic        err_pulse_o,
    output logic [15:0] err_count_o
);

    localparam int unsigned FillW = $clog2(LFSR_W);
    localparam int unsigned GoodW = $clog2(SYNC_CHECKS + 1);
    localparam int unsigned BadW  = $clog2(LOSS_LIMIT + 1);

    localparam logic [FillW-1:0] FillLast = FillW'(LFSR_W - 1);
    localparam logic [GoodW-1:0] GoodLast = GoodW'(SYNC_CHECKS - 1);
    localparam logic [BadW-1:0]  BadLast  = BadW'(LOSS_LIMIT - 1);

    state_e            state_q;
    logic [LFSR_W-1:0] win_q;
    logic [FillW-1:0]  fill_q;
    logic [GoodW-1:0]  good_q;
    logic [BadW-1:0]   bad_q;
    logic              locked_q;
    logic              err_pulse_q;

    logic pred;
    logic match;
    logic err_hit;

    lfsr_predict u_predict (
        .w_i (win_q),
        .p_o (pred)
    );

    assign match   = (bit_in_i == pred);
    assign err_hit = bit_valid_i && (state_q == StLocked) && !match;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StFill;
            win_q       <= '0;
            fill_q      <= '0;
            good_q      <= '0;
            bad_q       <= '0;
            locked_q    <= 1'b0;
            err_pulse_q <= 1'b0;
        end else begin
            err_pulse_q <= err_hit;
            if (bit_valid_i) begin
                unique case (state_q)
                    StFill: begin
                        win_q <= {bit_in_i, win_q[LFSR_W-1:1]};
                        if (fill_q == FillLast) begin
                            state_q <= StVerify;
                            fill_q  <= '0;
                            good_q  <= '0;
                        end else begin
                            fill_q <= fill_q + 1'b1;
                        end
                    end
                    StVerify: begin
                        win_q <= {bit_in_i, win_q[LFSR_W-1:1]};
                        // The all-ones window is a fixed point of the XNOR rule, so it never counts.
                        if (win_q == LOCKUP) begin
                            good_q <= '0;
                        end else if (match) begin
                            if (good_q == GoodLast) begin
                                state_q  <= StLocked;
                                locked_q <= 1'b1;
                                good_q   <= '0;
                                bad_q    <= '0;
                            end else begin
                                good_q <= good_q + 1'b1;
                            end
                        end else begin
                            good_q <= '0;
                        end
                    end
                    StLocked: begin
                        // Flywheel: shift in the prediction so corrupted bits never reach the window.
                        win_q <= {pred, win_q[LFSR_W-1:1]};
                        if (match) begin
                            bad_q <= '0;
                        end else if (bad_q == BadLast) begin
                            state_q  <= StFill;
                            locked_q <= 1'b0;
                            fill_q   <= '0;
                            bad_q    <= '0;
                        end else begin
                            bad_q <= bad_q + 1'b1;
                        end
                    end
                    default: begin
                        state_q  <= StFill;
                        locked_q <= 1'b0;
                        fill_q   <= '0;
                    end
                endcase
            end
        end
    end

`ifdef LFSR_CHK_ERRCNT_EN
    logic [15:0] err_count_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            err_count_q <= '0;
        end else if (err_hit && (err_count_q != 16'hFFFF)) begin
            err_count_q <= err_count_q + 16'd1;
        end
    end

    assign err_count_o = err_count_q;
`else
    assign err_count_o = 16'h0000;
`endif

    assign locked_o    = locked_q;
    assign err_pulse_o = err_pulse_q;

endmodule

// File: tb/tb_lfsr_checker.sv
// Directed and randomized bench for lfsr_checker against a queue-based model of the
// receiver and an arithmetic LFSR generator.
module tb_lfsr_checker;

    localparam int SYNC = 8;
    localparam int LOSS = 4;
    localparam int PH_FILL = 0, PH_VERIFY = 1, PH_LOCK = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        bit_valid = 1'b0;
    logic        bit_in = 1'b0;
    logic        locked;
    logic        err_pulse;
    logic [15:0] err_count;

    int checks = 0;
    int errors = 0;

    // Reference model state: last ten window bits, oldest at index 0.
    bit win[$];
    int phase, nfill, ngood, nbad, mcnt;
    bit m_locked, m_pulse;
    int gen;

    lfsr_checker #(
        .SYNC_CHECKS (SYNC),
        .LOSS_LIMIT  (LOSS)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .bit_valid_i (bit_valid),
        .bit_in_i    (bit_in),
        .locked_o    (locked),
        .err_pulse_o (err_pulse),
        .err_count_o (err_count)
    );

    always #5 clk = ~clk;

    function automatic int exp_errs(input int n);
`ifdef LFSR_CHK_ERRCNT_EN
        return n;
`else
        return 0;
`endif
    endfunction

    task check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task gen_next(output bit b);
        int nb;
        b   = bit'(gen & 1);
        nb  = ~((gen >> 3) ^ gen) & 1;
        gen = (gen >> 1) | (nb << 9);
    endtask

    task model_reset();
        win.delete();
        for (int i = 0; i < 10; i++) win.push_back(1'b0);
        phase = PH_FILL; nfill = 0; ngood = 0; nbad = 0; mcnt = 0;
        m_locked = 1'b0; m_pulse = 1'b0;
    endtask

    task push_win(input bit b);
        win.push_back(b);
        void'(win.pop_front());
    endtask

    task model_step(input bit v, input bit b);
        bit p;
        int ones;
        m_pulse = 1'b0;
        if (v) begin
            p = !(win[3] ^ win[0]);
            ones = 0;
            foreach (win[i]) ones += int'(win[i]);
            case (phase)
                PH_FILL: begin
                    push_win(b);
                    nfill++;
                    if (nfill == 10) begin phase = PH_VERIFY; ngood = 0; end
                end
                PH_VERIFY: begin
                    push_win(b);
                    if (ones == 10) ngood = 0;
                    else if (b == p) begin
                        ngood++;
                        if (ngood == SYNC) begin phase = PH_LOCK; m_locked = 1'b1; nbad = 0; end
                    end else ngood = 0;
                end
                default: begin
                    push_win(p);
                    if (b != p) begin
                        m_pulse = 1'b1;
                        if (mcnt < 65535) mcnt++;
                        nbad++;
                        if (nbad == LOSS) begin
                            phase = PH_FILL; nfill = 0; nbad = 0; m_locked = 1'b0;
                        end
                    end else nbad = 0;
                end
            endcase
        end
    endtask

    task cyc(input bit v, input bit b);
        @(negedge clk);
        bit_valid = v;
        bit_in    = b;
        @(posedge clk);
        #1;
        model_step(v, b);
        check("locked", locked, m_locked);
        check("err_pulse", err_pulse, m_pulse);
        check("err_count", err_count, exp_errs(mcnt));
    endtask

    task do_reset();
        @(negedge clk);
        reset     = 1'b1;
        bit_valid = 1'b0;
        @(posedge clk);
        #1;
        model_reset();
        gen = 0;
        check("rst_locked", locked, 0);
        check("rst_err_pulse", err_pulse, 0);
        check("rst_err_count", err_count, 0);
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        bit b;
        int first, pulses, ever;
        bit v;

        // Reset state
        do_reset();

        // Clean generator stream from reset: lock after exactly 10 + SYNC bits
        first = 0;
        for (int k = 1; k <= 1000; k++) begin
            gen_next(b);
            cyc(1'b1, b);
            if (locked && first == 0) first = k;
        end
        check("lock_latency", first, 10 + SYNC);
        check("clean_err_count", err_count, 0);

        // Single corrupted bit while locked: one pulse, lock held, flywheel recovers
        gen_next(b);
        cyc(1'b1, !b);
        check("flip_pulse", err_pulse, 1);
        check("flip_locked", locked, 1);
        pulses = 0;
        for (int k = 0; k < 50; k++) begin
            gen_next(b);
            cyc(1'b1, b);
            pulses += int'(err_pulse);
        end
        check("flip_no_more_errs", pulses, 0);
        check("flip_err_count", err_count, exp_errs(1));

        // LOSS consecutive wrong bits drop lock on the last one
        pulses = 0;
        for (int k = 0; k < LOSS; k++) begin
            gen_next(b);
            cyc(1'b1, !b);
            pulses += int'(err_pulse);
            if (k == LOSS - 2) check("loss_still_locked", locked, 1);
        end
        check("loss_pulses", pulses, LOSS);
        check("loss_unlocked", locked, 0);
        first = 0;
        for (int k = 1; k <= 40; k++) begin
            gen_next(b);
            cyc(1'b1, b);
            if (locked && first == 0) first = k;
        end
        check("relock_latency", first, 10 + SYNC);
        check("retained_err_count", err_count, exp_errs(5));

        // Reset while locked with five recorded errors
        check("pre_reset_locked", locked, 1);
        do_reset();

        // Constant ones: stuck at the lockup window, never locks
        ever = 0;
        for (int k = 0; k < 200; k++) begin
            cyc(1'b1, 1'b1);
            ever |= int'(locked);
        end
        check("ones_never_lock", ever, 0);
        check("ones_err_count", err_count, 0);

        // bit_valid toggling: 18th valid bit lands on cycle 35
        do_reset();
        first = 0;
        for (int c = 1; c <= 60; c++) begin
            v = (c % 2) == 1;
            if (v) gen_next(b);
            else b = bit'($urandom_range(0, 1));
            cyc(v, b);
            if (locked && first == 0) first = c;
        end
        check("toggle_lock_cycle", first, 2 * (10 + SYNC) - 1);

        // Randomized valid gaps, sparse corruptions and occasional bursts
        do_reset();
        for (int c = 0; c < 4000; c++) begin
            v = $urandom_range(0, 3) != 0;
            if (v) begin
                gen_next(b);
                if ($urandom_range(0, 59) == 0) b = !b;
                if ($urandom_range(0, 499) == 0) begin
                    for (int j = 0; j < LOSS; j++) begin
                        cyc(1'b1, !b);
                        gen_next(b);
                    end
                end
            end else begin
                b = bit'($urandom_range(0, 1));
            end
            cyc(v, b);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
